hazard_control_unit: RTL and testbench
======================================

# hazard_control_unit

Pipeline hazard sequencer for the 5-stage RV32 core. Detects load-use hazards that the operand forwarding path cannot cover, sequences multi-cycle mul/div occupancy of EX, applies branch/jump redirect flushes, and honours data-memory wait. Drives write-enable and flush controls of PC, IF/ID, ID/EX and EX/MEM; forwarding-mux selection stays in the forwarding unit.

## Interface
- MULDIV_LATENCY, 4: total cycles a mul/div op occupies EX; legal 2..16.
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rs1_id, rs2_id  in  5  source registers of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1  ID instruction actually reads rs1/rs2.
- rd_ex  in  5  destination of the instruction in EX.
- mem_read_ex  in  1  EX instruction is a load.
- muldiv_ex  in  1  EX instruction is a multi-cycle mul/div.
- branch_taken_ex  in  1  EX resolved a taken branch/jump (redirect).
- mem_busy  in  1  data memory wait; whole pipeline must freeze.
- pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en  out  1  stage register enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble into that stage register.
- md_busy  out  1  FSM in MD_BUSY.

## Operation
- FSM states: IDLE, MD_BUSY. 4-bit counter md_cnt.
- Outputs are combinational from state, md_cnt and inputs. Default: all wr_en=1, all flush=0.
- Priority (highest first): rst, mem_busy, mul/div sequencing, branch redirect, load-use.
- rst=1: all wr_en=0, all flush=1, md_busy=0. State -> IDLE, md_cnt -> 0.
- mem_busy=1: all wr_en=0, all flush=0; state and md_cnt frozen. Pending redirect/load-use is applied on the first cycle mem_busy=0.
- IDLE, muldiv_ex=1: pc/if_id/id_ex wr_en=0, ex_mem_flush=1; md_cnt<=1; ->MD_BUSY.
- MD_BUSY, md_cnt!=MULDIV_LATENCY-1: same stall outputs; md_cnt++.
- MD_BUSY, md_cnt==MULDIV_LATENCY-1: default outputs, so the result advances; ->IDLE, md_cnt<=0.
- Net: LATENCY-1 stall cycles per op. Back-to-back mul/div ops each restart from IDLE.
- IDLE, branch_taken_ex=1: pc_wr_en=1 (target), if_id_flush=1, id_ex_flush=1. Load-use is suppressed because the ID instruction is squashed.
- IDLE, load-use: mem_read_ex && rd_ex!=0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)). Outputs: pc_wr_en=0, if_id_wr_en=0, id_ex_flush=1. Exactly one cycle; the next cycle is served by MEM->EX forwarding.
- muldiv_ex with branch_taken_ex in the same cycle is illegal; mul/div wins.
- In MD_BUSY, branch_taken_ex and load-use are ignored.

## Timing
- Zero-latency combinational controls within the cycle. State and counter update on posedge clk.
- rst asynchronous: outputs take their reset values immediately on assertion, not at a clock edge. First normal cycle follows the first posedge after deassertion.
- Reset mid mul/div aborts the sequence; no residual stall after reset.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds output stall_cycle_cnt (out, 32).
  - Counts cycles with rst=0 and pc_wr_en=0, including mem_busy and load-use cycles.
  - Wraps 0xFFFFFFFF->0. Resets to 0.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Load-use: mem_read_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 -> one cycle of pc_wr_en=0, if_id_wr_en=0, id_ex_flush=1, then defaults. Repeat with rd_ex=0 or rs1_used_id=0 -> no stall.
- Mul/div, MULDIV_LATENCY=4: pulse muldiv_ex -> exactly 3 stall cycles with ex_mem_flush=1, md_busy=1 on cycles 2-3, release on cycle 4. Back-to-back ops -> 3+3 stalls.
- Redirect coincident with load-use (branch_taken_ex=1, load-use true) -> if_id_flush=1, id_ex_flush=1, pc_wr_en=1, no stall.
- mem_busy asserted for 5 cycles at md_cnt=2 -> all wr_en=0 and no flush for 5 cycles; md_cnt holds at 2; remaining stalls complete afterward.
- Async rst asserted mid MD_BUSY between edges -> outputs go to reset values immediately; after release, IDLE with md_busy=0. With HAZARD_PERF_CNT_EN, stall_cycle_cnt=0.
- HAZARD_PERF_CNT_EN: preload scenario totals (1 load-use + 3 mul/div stalls) -> stall_cycle_cnt=4.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer for the 5-stage RV32 core.
// Drives stage-register write enables and bubble flushes for load-use stalls,
// multi-cycle mul/div occupancy of EX, taken-branch redirects and data-memory wait.
// Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycle_cnt output.
module hazard_control_unit #(
  parameter int unsigned MULDIV_LATENCY = 4  // total EX cycles per mul/div, 2..16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic        rs1_used_id,
  input  logic        rs2_used_id,
  input  logic [4:0]  rd_ex,
  input  logic        mem_read_ex,
  input  logic        muldiv_ex,
  input  logic        branch_taken_ex,
  input  logic        mem_busy,
  output logic        pc_wr_en,
  output logic        if_id_wr_en,
  output logic        id_ex_wr_en,
  output logic        ex_mem_wr_en,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycle_cnt
`endif
);

  typedef enum logic {StIdle, StMdBusy} state_t;

  // Counter value on the cycle the mul/div result is released to MEM.
  localparam logic [3:0] MdLast = 4'(MULDIV_LATENCY - 1);

  state_t     state;
  logic [3:0] md_cnt;
  logic       load_use;
  logic       md_stall;

  assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                    ((rs1_used_id && (rs1_id == rd_ex)) ||
                     (rs2_used_id && (rs2_id == rd_ex)));

  // Hold the front end while a mul/div occupies EX, up to its release cycle.
  assign md_stall = ((state == StIdle) && muldiv_ex) ||
                    ((state == StMdBusy) && (md_cnt != MdLast));

  // Mul/div occupancy sequencer; frozen while data memory is waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= StIdle;
      md_cnt <= 4'd0;
    end else if (!mem_busy) begin
      unique case (state)
        StIdle: begin
          if (muldiv_ex) begin
            state  <= StMdBusy;
            md_cnt <= 4'd1;
          end
        end
        StMdBusy: begin
          if (md_cnt == MdLast) begin
            state  <= StIdle;
            md_cnt <= 4'd0;
          end else begin
            md_cnt <= md_cnt + 4'd1;
          end
        end
        default: begin
          state  <= StIdle;
          md_cnt <= 4'd0;
        end
      endcase
    end
  end

  // Prioritised stage controls: reset, memory wait, mul/div, redirect, load-use.
  always_comb begin
    pc_wr_en     = 1'b1;
    if_id_wr_en  = 1'b1;
    id_ex_wr_en  = 1'b1;
    ex_mem_wr_en = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_busy      = (state == StMdBusy) && !rst;
    if (rst) begin
      pc_wr_en     = 1'b0;
      if_id_wr_en  = 1'b0;
      id_ex_wr_en  = 1'b0;
      ex_mem_wr_en = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (mem_busy) begin
      // Freeze everything; pending redirect/load-use re-evaluates once the wait drops.
      pc_wr_en     = 1'b0;
      if_id_wr_en  = 1'b0;
      id_ex_wr_en  = 1'b0;
      ex_mem_wr_en = 1'b0;
    end else if (md_stall) begin
      // Op stays in EX; feed MEM a bubble until the result is ready.
      pc_wr_en     = 1'b0;
      if_id_wr_en  = 1'b0;
      id_ex_wr_en  = 1'b0;
      ex_mem_flush = 1'b1;
    end else if ((state == StIdle) && branch_taken_ex) begin
      // ID instruction is squashed, so any load-use against it is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if ((state == StIdle) && load_use) begin
      pc_wr_en    = 1'b0;
      if_id_wr_en = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Count every non-reset cycle where the PC is held; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 32'd0;
    end else if (!pc_wr_en) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycle_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed self-checking bench for hazard_control_unit (MULDIV_LATENCY = 4).
// Output vector order: {pc, if_id, id_ex, ex_mem wr_en, if_id, id_ex, ex_mem flush, md_busy}.
module tb_hazard_control_unit;

  localparam logic [7:0] DEF = 8'b1111_0000;  // default
  localparam logic [7:0] RST = 8'b0000_1110;  // reset
  localparam logic [7:0] LU  = 8'b0011_0100;  // load-use stall
  localparam logic [7:0] MDI = 8'b0001_0010;  // mul/div stall, first cycle (IDLE)
  localparam logic [7:0] MDB = 8'b0001_0011;  // mul/div stall while MD_BUSY
  localparam logic [7:0] REL = 8'b1111_0001;  // mul/div release cycle
  localparam logic [7:0] BR  = 8'b1111_1100;  // redirect
  localparam logic [7:0] MBI = 8'b0000_0000;  // memory wait, idle
  localparam logic [7:0] MBB = 8'b0000_0001;  // memory wait, mul/div in progress

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       rs1_used_id, rs2_used_id, mem_read_ex, muldiv_ex, branch_taken_ex, mem_busy;
  logic       pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, md_busy;
  logic [7:0] outs;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign outs = {pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en,
                 if_id_flush, id_ex_flush, ex_mem_flush, md_busy};

  hazard_control_unit #(.MULDIV_LATENCY(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_id          (rs1_id),
    .rs2_id          (rs2_id),
    .rs1_used_id     (rs1_used_id),
    .rs2_used_id     (rs2_used_id),
    .rd_ex           (rd_ex),
    .mem_read_ex     (mem_read_ex),
    .muldiv_ex       (muldiv_ex),
    .branch_taken_ex (branch_taken_ex),
    .mem_busy        (mem_busy),
    .pc_wr_en        (pc_wr_en),
    .if_id_wr_en     (if_id_wr_en),
    .id_ex_wr_en     (id_ex_wr_en),
    .ex_mem_wr_en    (ex_mem_wr_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .md_busy         (md_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycle_cnt (stall_cycle_cnt)
`endif
  );

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
    rs1_used_id = 1'b0; rs2_used_id = 1'b0;
    mem_read_ex = 1'b0; muldiv_ex = 1'b0; branch_taken_ex = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #2;
    checks++;
    if (outs !== RST) begin
      errors++; $display("FAIL reset_initial got %b exp %b", outs, RST);
    end
    tick();
    checks++;
    if (outs !== RST) begin
      errors++; $display("FAIL reset_held got %b exp %b", outs, RST);
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if (outs !== DEF) begin
      errors++; $display("FAIL reset_release got %b exp %b", outs, DEF);
    end
  endtask

  task automatic test_load_use();
    // {mem_read, rd, rs1, rs1_used, rs2, rs2_used} -> expected
    logic [17:0] vec [6];
    logic [7:0]  exp [6];
    vec = '{{1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0},   // rs1 hit
            {1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0},   // bubble after stall
            {1'b1, 5'd7, 5'd1, 1'b1, 5'd7, 1'b1},   // rs2 hit
            {1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1},   // rd_ex = x0
            {1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0},   // rs1 not used
            {1'b0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b1}};  // not a load
    exp = '{LU, DEF, LU, DEF, DEF, DEF};
    for (int i = 0; i < 6; i++) begin
      {mem_read_ex, rd_ex, rs1_id, rs1_used_id, rs2_id, rs2_used_id} = vec[i];
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL load_use[%0d] got %b exp %b", i, outs, exp[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_muldiv();
    logic [7:0] exp [5];
    exp = '{MDI, MDB, MDB, REL, DEF};
    for (int i = 0; i < 5; i++) begin
      muldiv_ex = (i < 4);
      // Load-use and redirect must be ignored while busy.
      mem_read_ex = (i == 2); rd_ex = 5'd3; rs1_id = 5'd3; rs1_used_id = 1'b1;
      branch_taken_ex = (i == 1);
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL muldiv[%0d] got %b exp %b", i, outs, exp[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [9];
    exp = '{MDI, MDB, MDB, REL, MDI, MDB, MDB, REL, DEF};
    for (int i = 0; i < 9; i++) begin
      muldiv_ex = (i < 8);
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL back_to_back[%0d] got %b exp %b", i, outs, exp[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_redirect_load_use();
    branch_taken_ex = 1'b1;
    mem_read_ex = 1'b1; rd_ex = 5'd9; rs2_id = 5'd9; rs2_used_id = 1'b1;
    #1;
    checks++;
    if (outs !== BR) begin
      errors++; $display("FAIL redirect_load_use got %b exp %b", outs, BR);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (outs !== DEF) begin
      errors++; $display("FAIL redirect_after got %b exp %b", outs, DEF);
    end
    tick();
  endtask

  task automatic test_mem_busy();
    logic [7:0] exp [11];
    exp = '{MDI, MDB, MBB, MBB, MBB, MBB, MBB, MDB, REL, DEF, DEF};
    for (int i = 0; i < 11; i++) begin
      muldiv_ex = (i < 9);
      mem_busy  = (i >= 2) && (i <= 6);
      #1;
      checks++;
      if (outs !== exp[i]) begin
        errors++; $display("FAIL mem_busy_md[%0d] got %b exp %b", i, outs, exp[i]);
      end
      tick();
    end
    // Load-use held off by memory wait, applied once the wait drops.
    mem_read_ex = 1'b1; rd_ex = 5'd4; rs1_id = 5'd4; rs1_used_id = 1'b1; mem_busy = 1'b1;
    #1;
    checks++;
    if (outs !== MBI) begin
      errors++; $display("FAIL mem_busy_lu_wait got %b exp %b", outs, MBI);
    end
    tick();
    mem_busy = 1'b0;
    #1;
    checks++;
    if (outs !== LU) begin
      errors++; $display("FAIL mem_busy_lu_apply got %b exp %b", outs, LU);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset();
    muldiv_ex = 1'b1;
    tick();
    tick();
    #3 rst = 1'b1;  // between edges
    #1;
    checks++;
    if (outs !== RST) begin
      errors++; $display("FAIL async_reset got %b exp %b", outs, RST);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if (stall_cycle_cnt !== 32'd0) begin
      errors++; $display("FAIL async_reset_cnt got %0d exp 0", stall_cycle_cnt);
    end
`endif
    #1;
    rst = 1'b0;
    muldiv_ex = 1'b0;
    #1;
    checks++;
    if (outs !== DEF) begin
      errors++; $display("FAIL async_release got %b exp %b", outs, DEF);
    end
    tick();
    checks++;
    if (outs !== DEF) begin
      errors++; $display("FAIL async_after_edge got %b exp %b", outs, DEF);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst = 1'b1;
    #1 rst = 1'b0;
    tick();
    mem_read_ex = 1'b1; rd_ex = 5'd6; rs1_id = 5'd6; rs1_used_id = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      muldiv_ex = 1'b1;
      tick();
    end
    idle_inputs();
    tick();
    checks++;
    if (stall_cycle_cnt !== 32'd4) begin
      errors++; $display("FAIL perf_cnt got %0d exp 4", stall_cycle_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_back_to_back();
    test_redirect_load_use();
    test_mem_busy();
    test_async_reset();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
